// File: rtl/mem_ram_adapter.sv
// Adapter between the core memory port and a 32-bit word-addressed synchronous RAM.
// Unaligned byte/half/word accesses that straddle a word boundary are issued as two RAM beats.
package mem_types_pkg;
    typedef enum logic [2:0] {
        MEM_CTRL_NONE        = 3'd0,
        MEM_CTRL_READ_BYTE   = 3'd1,
        MEM_CTRL_READ_HALF   = 3'd2,
        MEM_CTRL_READ_WORD   = 3'd3,
        MEM_CTRL_STORE_BYTE  = 3'd5,
        MEM_CTRL_STORE_HALF  = 3'd6,
        MEM_CTRL_STORE_WORD  = 3'd7
    } mem_ctrl_t;
endpackage

module mem_ram_adapter
    import mem_types_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  mem_ctrl_t         mem_ctrl,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_din,
    output logic [31:0]       mem_dout,
    output logic              mem_ready,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_BEAT1, S_FETCH, S_RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t              r_state, w_state_nxt;
    logic                r_store, r_split;
    logic [1:0]          r_size, r_off;
    logic [ADDR_W-1:0]   r_w;
    logic [31:0]         r_din, r_lo;

    logic                r_ram_en, w_ram_en_nxt;
    logic [3:0]          r_ram_we, w_ram_we_nxt;
    logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr_nxt;
    logic [31:0]         r_ram_wdata, w_ram_wdata_nxt;
    logic [31:0]         r_mem_dout, w_mem_dout_nxt;
    logic                r_mem_ready, w_mem_ready_nxt;

    logic                w_req, w_store, w_split, w_accept, w_unused_addr;
    logic [1:0]          w_size, w_off;
    logic [31:0]         w_hi, w_lo, w_merged;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 4'b0001;
            SZ_HALF: return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] size_zext(input logic [31:0] d, input logic [1:0] size);
        case (size)
            SZ_BYTE: return d & 32'h0000_00FF;
            SZ_HALF: return d & 32'h0000_FFFF;
            default: return d;
        endcase
    endfunction

    // Undefined encodings fall through to "no request".
    always_comb begin
        w_req   = 1'b1;
        w_store = 1'b0;
        w_size  = SZ_BYTE;
        case (mem_ctrl)
            MEM_CTRL_READ_BYTE:  w_size = SZ_BYTE;
            MEM_CTRL_READ_HALF:  w_size = SZ_HALF;
            MEM_CTRL_READ_WORD:  w_size = SZ_WORD;
            MEM_CTRL_STORE_BYTE: begin w_store = 1'b1; w_size = SZ_BYTE; end
            MEM_CTRL_STORE_HALF: begin w_store = 1'b1; w_size = SZ_HALF; end
            MEM_CTRL_STORE_WORD: begin w_store = 1'b1; w_size = SZ_WORD; end
            default:             w_req = 1'b0;
        endcase
    end

    assign w_off         = mem_addr[1:0];
    assign w_split       = ({1'b0, w_off} + size_bytes(w_size)) > 3'd4;
    assign w_accept      = (r_state == S_IDLE) && w_req;
    assign w_unused_addr = ^mem_addr[31:ADDR_W+2];

    // Shifting by 32 yields zero, so off=0 naturally drops the high word.
    assign w_hi     = r_split ? ram_rdata : 32'd0;
    assign w_lo     = r_split ? r_lo : ram_rdata;
    assign w_merged = (w_lo >> {r_off, 3'b000}) | (w_hi << (6'd32 - {1'b0, r_off, 3'b000}));

    always_comb begin
        w_state_nxt     = r_state;
        w_ram_en_nxt    = 1'b0;
        w_ram_we_nxt    = 4'b0000;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;
        w_mem_dout_nxt  = r_mem_dout;
        w_mem_ready_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = S_BEAT0;
                    w_ram_en_nxt   = 1'b1;
                    w_ram_addr_nxt = mem_addr[ADDR_W+1:2];
                    if (w_store) begin
                        w_ram_we_nxt    = size_mask(w_size) << w_off;
                        w_ram_wdata_nxt = mem_din << {w_off, 3'b000};
                    end
                end
            end
            S_BEAT0: begin
                if (r_split) begin
                    w_state_nxt    = S_BEAT1;
                    w_ram_en_nxt   = 1'b1;
                    w_ram_addr_nxt = r_w + ADDR_W'(1);
                    if (r_store) begin
                        w_ram_we_nxt    = size_mask(r_size) >> (3'd4 - {1'b0, r_off});
                        w_ram_wdata_nxt = r_din >> (6'd32 - {1'b0, r_off, 3'b000});
                    end
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_BEAT1: w_state_nxt = S_FETCH;
            S_FETCH: begin
                w_state_nxt     = S_RESP;
                w_mem_ready_nxt = 1'b1;
                if (!r_store) begin
                    w_mem_dout_nxt = size_zext(w_merged, r_size);
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 4'b0000;
            r_ram_addr  <= '0;
            r_ram_wdata <= 32'd0;
            r_mem_dout  <= 32'd0;
            r_mem_ready <= 1'b0;
            r_store     <= 1'b0;
            r_split     <= 1'b0;
            r_size      <= SZ_BYTE;
            r_off       <= 2'd0;
            r_w         <= '0;
            r_din       <= 32'd0;
            r_lo        <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_ram_en    <= w_ram_en_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_mem_dout  <= w_mem_dout_nxt;
            r_mem_ready <= w_mem_ready_nxt;
            if (w_accept) begin
                r_store <= w_store;
                r_split <= w_split;
                r_size  <= w_size;
                r_off   <= w_off;
                r_w     <= mem_addr[ADDR_W+1:2];
                r_din   <= mem_din;
            end
            // Beat-0 read data arrives while the second beat is on the bus.
            if (r_state == S_BEAT1) begin
                r_lo <= ram_rdata;
            end
        end
    end

    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign mem_dout  = r_mem_dout;
    assign mem_ready = r_mem_ready;

endmodule

// File: tb/tb_mem_ram_adapter.sv
// Directed bench for mem_ram_adapter: behavioural word RAM plus hand-computed expectations.
module tb_mem_ram_adapter;
    import mem_types_pkg::*;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    mem_ctrl_t         mem_ctrl;
    logic [31:0]       mem_addr, mem_din, mem_dout;
    logic              mem_ready;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;

    logic [31:0]       ram_mem [0:(1<<ADDR_W)-1];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [31:0]       pl_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] b_addr  [2];
    logic [31:0] b_we    [2];
    logic [31:0] b_wdata [2];
    int          nbeats, lat;
    logic [31:0] rd;
    logic [7:0]  en_h, rdy_h;
    int          stray;

    mem_ram_adapter #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_ctrl  (mem_ctrl),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_ready (mem_ready),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) begin
            ram_mem[pl_addr] <= pl_data;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = ADDR_W'(a);
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    // Issue one request, record every beat, wait (bounded) for mem_ready, then drop the request.
    task automatic run_op(input mem_ctrl_t c, input logic [31:0] a, input logic [31:0] d);
        logic done;
        mem_ctrl = c;
        mem_addr = a;
        mem_din  = d;
        nbeats   = 0;
        lat      = 0;
        done     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            b_addr[i] = 'x; b_we[i] = 'x; b_wdata[i] = 'x;
        end
        while (!done && lat < 20) begin
            tick();
            lat++;
            if (ram_en) begin
                if (nbeats < 2) begin
                    b_addr[nbeats]  = 32'(ram_addr);
                    b_we[nbeats]    = 32'(ram_we);
                    b_wdata[nbeats] = ram_wdata;
                end
                nbeats++;
            end
            if (mem_ready) done = 1'b1;
        end
        rd = mem_dout;
        check("ready_seen", 32'(done), 32'd1);
        mem_ctrl = MEM_CTRL_NONE;
        tick();
        check("ready_single", 32'(mem_ready), 32'd0);
    endtask

    initial begin
        rst      = 1'b0;
        mem_ctrl = MEM_CTRL_NONE;
        mem_addr = 32'd0;
        mem_din  = 32'd0;
        pl_en    = 1'b0;
        pl_addr  = '0;
        pl_data  = 32'd0;
        tick();
        tick();
        preload(0,    32'h4433_2211);
        preload(1,    32'h8877_6655);
        preload(2,    32'h0000_0000);
        preload(1023, 32'h1122_3344);
        check("rst_ram_en",    32'(ram_en),    32'd0);
        check("rst_ram_we",    32'(ram_we),    32'd0);
        check("rst_ram_addr",  32'(ram_addr),  32'd0);
        check("rst_ram_wdata", ram_wdata,      32'd0);
        check("rst_mem_dout",  mem_dout,       32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        rst = 1'b1;
        tick();

        run_op(MEM_CTRL_READ_WORD, 32'h0, 32'h0);
        check("rw0_lat",    32'(lat),    32'd3);
        check("rw0_beats",  32'(nbeats), 32'd1);
        check("rw0_addr",   b_addr[0],   32'd0);
        check("rw0_we",     b_we[0],     32'd0);
        check("rw0_dout",   rd,          32'h4433_2211);

        run_op(MEM_CTRL_READ_HALF, 32'h3, 32'h0);
        check("rh3_lat",    32'(lat),    32'd4);
        check("rh3_beats",  32'(nbeats), 32'd2);
        check("rh3_addr0",  b_addr[0],   32'd0);
        check("rh3_addr1",  b_addr[1],   32'd1);
        check("rh3_we1",    b_we[1],     32'd0);
        check("rh3_dout",   rd,          32'h0000_5544);

        run_op(MEM_CTRL_READ_BYTE, 32'h6, 32'h0);
        check("rb6_lat",    32'(lat),    32'd3);
        check("rb6_dout",   rd,          32'h0000_0077);

        run_op(MEM_CTRL_STORE_WORD, 32'h2, 32'hDEAD_BEEF);
        check("sw2_lat",    32'(lat),    32'd4);
        check("sw2_beats",  32'(nbeats), 32'd2);
        check("sw2_addr0",  b_addr[0],   32'd0);
        check("sw2_we0",    b_we[0],     32'h0000_000C);
        check("sw2_wd0",    b_wdata[0],  32'hBEEF_0000);
        check("sw2_addr1",  b_addr[1],   32'd1);
        check("sw2_we1",    b_we[1],     32'h0000_0003);
        check("sw2_wd1",    b_wdata[1],  32'h0000_DEAD);
        check("sw2_dout_held", rd,       32'h0000_0077);

        run_op(MEM_CTRL_READ_WORD, 32'h0, 32'h0);
        check("rw0_after_sw", rd, 32'hBEEF_2211);
        run_op(MEM_CTRL_READ_WORD, 32'h4, 32'h0);
        check("rw4_after_sw", rd, 32'h8877_DEAD);

        run_op(MEM_CTRL_STORE_BYTE, 32'h9, 32'h0000_00AB);
        check("sb9_beats",  32'(nbeats), 32'd1);
        check("sb9_addr",   b_addr[0],   32'd2);
        check("sb9_we",     b_we[0],     32'h0000_0002);
        check("sb9_wd",     b_wdata[0],  32'h0000_AB00);
        run_op(MEM_CTRL_READ_HALF, 32'h8, 32'h0);
        check("rh8_dout",   rd,          32'h0000_AB00);

        run_op(MEM_CTRL_READ_WORD, 32'h0000_0FFE, 32'h0);
        check("wrap_beats", 32'(nbeats), 32'd2);
        check("wrap_addr0", b_addr[0],   32'd1023);
        check("wrap_addr1", b_addr[1],   32'd0);
        check("wrap_dout",  rd,          32'h2211_1122);

        run_op(MEM_CTRL_READ_BYTE, 32'h0000_1006, 32'h0);
        check("alias_addr", b_addr[0],   32'd1);
        check("alias_dout", rd,          32'h0000_0077);

        mem_ctrl = mem_ctrl_t'(3'd4);
        mem_addr = 32'h0;
        stray    = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ram_en || mem_ready) stray++;
        end
        check("undef_ctrl_idle", 32'(stray), 32'd0);
        mem_ctrl = MEM_CTRL_NONE;
        tick();

        mem_ctrl = MEM_CTRL_READ_WORD;
        mem_addr = 32'h0;
        for (int i = 0; i < 8; i++) begin
            tick();
            en_h[i]  = ram_en;
            rdy_h[i] = mem_ready;
        end
        check("held_en_pattern",  32'(en_h),  32'h0000_0011);
        check("held_rdy_pattern", 32'(rdy_h), 32'h0000_0044);
        check("held_dout",        mem_dout,   32'hBEEF_2211);
        mem_ctrl = MEM_CTRL_NONE;
        tick();

        mem_ctrl = MEM_CTRL_STORE_HALF;
        mem_addr = 32'h7;
        mem_din  = 32'h0000_1234;
        tick();
        check("abort_b0_addr",  32'(ram_addr), 32'd1);
        check("abort_b0_we",    32'(ram_we),   32'h0000_0008);
        check("abort_b0_wd",    ram_wdata,     32'h3400_0000);
        tick();
        check("abort_b1_addr",  32'(ram_addr), 32'd2);
        check("abort_b1_we",    32'(ram_we),   32'h0000_0001);
        check("abort_b1_wd",    ram_wdata,     32'h0000_0012);
        rst = 1'b0;
        tick();
        check("abort_en",    32'(ram_en),    32'd0);
        check("abort_we",    32'(ram_we),    32'd0);
        check("abort_ready", 32'(mem_ready), 32'd0);
        check("abort_dout",  mem_dout,       32'd0);
        tick();
        check("abort_ready2", 32'(mem_ready), 32'd0);
        rst = 1'b1;
        run_op(MEM_CTRL_STORE_HALF, 32'h7, 32'h0000_1234);
        check("resume_lat",   32'(lat),    32'd4);
        check("resume_beats", 32'(nbeats), 32'd2);
        run_op(MEM_CTRL_READ_WORD, 32'h4, 32'h0);
        check("resume_w1", rd, 32'h3477_DEAD);
        run_op(MEM_CTRL_READ_WORD, 32'h8, 32'h0);
        check("resume_w2", rd, 32'h0000_AB12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ram_adapter.md
Name: mem_ram_adapter

Overview:
- Synthesizable memory stage directly downstream of the core's memory port (mem_ctrl/mem_addr/mem_din/mem_dout).
- Converts byte/half/word reads and stores at any byte address into accesses on a 32-bit, word-addressed synchronous RAM with per-byte write enables and 1-cycle read latency.
- Splits accesses that cross a word boundary into two RAM beats and merges the read data.
- Zero-extends read data and signals completion to the core with a one-cycle mem_ready pulse.

Parameters:
- ADDR_W, 10: RAM word-address width. Capacity is 4*2^ADDR_W bytes. Byte-address bits above ADDR_W+1 are ignored (aliasing).

Ports:
- clk  in  1  clock
- rst  in  1  one clock; reset is synchronous and active-low
- mem_ctrl  in  mem_ctrl_t (types.sv)  MEM_CTRL_NONE or one of MEM_CTRL_READ_/STORE_ BYTE/HALF/WORD
- mem_addr  in  32  byte address
- mem_din  in  32  store data, right-aligned
- mem_dout  out  32  read data, right-aligned, zero-extended
- mem_ready  out  1  one-cycle completion pulse
- ram_en  out  1  RAM access strobe
- ram_we  out  4  byte write enables; bit i covers bits [8i+7:8i]
- ram_addr  out  ADDR_W  word index
- ram_wdata  out  32  write data
- ram_rdata  in  32  read data, valid the cycle after the RAM samples ram_en

Behaviour:
- All outputs are registered.
- Reset (rst==0 at a clk edge):
  - state=IDLE.
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - mem_dout=0, mem_ready=0.
- Request protocol:
  - The core holds mem_ctrl/mem_addr/mem_din stable until it sees mem_ready.
  - Requests are accepted only in IDLE, when mem_ctrl!=NONE.
  - On acceptance, latch op, size, off=addr[1:0], word index w=addr[ADDR_W+1:2], and din.
  - Inputs are ignored outside IDLE.
- Split rule: an access is split iff off+size_bytes>4, i.e. HALF with off=3, or WORD with off!=0. BYTE never splits.
- States: IDLE, BEAT0, BEAT1, FETCH, RESP.
  - IDLE -> BEAT0 on acceptance. Drive ram_en=1, ram_addr=w, and for stores ram_we=(mask<<off)[3:0] and ram_wdata=din<<(8*off). mask is 0001, 0011 or 1111 by size.
  - BEAT0 -> BEAT1 if split. Drive ram_addr=(w+1) mod 2^ADDR_W, ram_we=mask>>(4-off) (stores), ram_wdata=din>>(8*(4-off)).
  - BEAT0 -> FETCH if not split. ram_en=0, ram_we=0.
  - BEAT1 -> FETCH. Latch lo=ram_rdata; ram_en=0, ram_we=0.
  - FETCH -> RESP. For reads, mem_dout = ({hi,lo}>>(8*off)) masked to size and zero-extended.
    - Split: hi=ram_rdata.
    - Non-split: lo=ram_rdata, hi=0.
    - Stores leave mem_dout unchanged.
  - RESP: mem_ready=1 for exactly this cycle. RESP -> IDLE unconditionally.
  - The request still held by the core during RESP is not re-accepted. The earliest next acceptance is the IDLE cycle after RESP.
- Latency from the acceptance edge k: mem_ready visible after edge k+2 for non-split, k+3 for split.
  - Each beat has ram_en high for exactly one cycle.
  - Read beats have ram_we=0.
- Wrap-around: the second beat's word index wraps modulo 2^ADDR_W.
- Reset mid-operation: abort immediately to the reset values.
  - No mem_ready for the aborted request.
  - A split store aborted after BEAT0 leaves beat 0 committed; this is accepted behaviour.
  - After reset releases, a still-held request is accepted as new.
- mem_ctrl values outside the defined set are treated as NONE.

Test Plan:
Preload RAM with word0=0x44332211, word1=0x88776655.
- READ_WORD addr 0x0 -> one ram_en cycle, ram_addr=0, ram_we=0; mem_dout=0x44332211; mem_ready a single cycle after edge k+2.
- READ_HALF addr 0x3 -> two beats at word 0 then word 1; mem_dout=0x00005544; mem_ready after edge k+3. READ_BYTE addr 0x6 -> 0x00000077.
- STORE_WORD addr 0x2, din 0xDEADBEEF -> beat0 word0 ram_we=1100 ram_wdata=0xBEEF0000; beat1 word1 ram_we=0011 ram_wdata=0x0000DEAD. Follow-up READ_WORD 0x0 -> 0xBEEF2211; READ_WORD 0x4 -> 0x8877DEAD.
- Wrap: READ_WORD at byte address 4*2^ADDR_W-2 -> beat0 ram_addr=2^ADDR_W-1, beat1 ram_addr=0.
- Held request: keep READ_WORD 0x0 asserted for 8 cycles -> exactly two mem_ready pulses; each is followed by an IDLE cycle before the next BEAT0.
- Reset low during BEAT1 of a split store -> next cycle ram_en=0, ram_we=0, mem_ready=0, mem_dout=0, and no ready pulse for that request. After release, the held request completes normally.
